// File: rtl/rot_stream_pkg.sv
// Shared widths and the byte rotate used by the rot_stream datapath.
package rot_stream_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned AMT_W  = 3;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [AMT_W-1:0]  amt_t;

  // Rotate right: the low amt bits wrap round to the top of the byte.
  function automatic data_t rotr(input data_t d, input amt_t amt);
    logic [2*DATA_W-1:0] dd;
    dd = {d, d} >> amt;
    return dd[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/rot_fifo.sv
// Power-of-two output FIFO with occupancy count; full/empty come from registered level only.
module rot_fifo
  import rot_stream_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LvlW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LvlW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign level_o = level_q;

  // Pointers are exactly log2(DEPTH) wide, so wrap modulo DEPTH is natural overflow.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (do_push) wptr_d = wptr_q + PtrW'(1);
    if (do_pop)  rptr_d = rptr_q + PtrW'(1);
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/rot_stream.sv
// Byte rotate stream: input stage S1 feeds a combinational rotate into an output FIFO.
module rot_stream
  import rot_stream_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [AMT_W-1:0]         in_amt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         acc_cnt
);

  logic             s1_v_q, s1_v_d;
  data_t            s1_data_q, s1_data_d;
  amt_t             s1_amt_q, s1_amt_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;

  logic  fifo_full, fifo_empty;
  logic  in_xfer, out_xfer, s1_push;
  data_t rot_data;

  // in_ready depends on registered state only, so it never waits on in_valid.
  assign in_ready  = !s1_v_q || !fifo_full;
  assign in_xfer   = in_valid && in_ready;
  assign s1_push   = s1_v_q && !fifo_full;
  assign out_valid = !fifo_empty;
  assign out_xfer  = out_valid && out_ready;
  assign rot_data  = rotr(s1_data_q, s1_amt_q);
  assign acc_cnt   = acc_cnt_q;

  always_comb begin
    s1_v_d    = s1_v_q;
    s1_data_d = s1_data_q;
    s1_amt_d  = s1_amt_q;
    acc_cnt_d = acc_cnt_q;
    if (s1_push) s1_v_d = 1'b0;
    if (in_xfer) begin
      s1_v_d    = 1'b1;
      s1_data_d = in_data;
      s1_amt_d  = in_amt;
      if (acc_cnt_q != '1) acc_cnt_d = acc_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_v_q    <= 1'b0;
      s1_data_q <= '0;
      s1_amt_q  <= '0;
      acc_cnt_q <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_data_q <= s1_data_d;
      s1_amt_q  <= s1_amt_d;
      acc_cnt_q <= acc_cnt_d;
    end
  end

  rot_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (s1_push),
    .wdata_i (rot_data),
    .pop_i   (out_xfer),
    .rdata_o (out_data),
    .level_o (level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A stalled head must not move, and occupancy can never pass DEPTH.
  a_head_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (out_valid && !out_ready) |=> $stable(out_data));
  a_level_bound: assert property (@(posedge clk) disable iff (!reset_n)
    level <= ($clog2(DEPTH) + 1)'(DEPTH));

endmodule
